// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary (non-power-of-two) depth, standard or first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 8,
   parameter  int AF_THRESH  = DEPTH - 2,
   parameter  int AE_THRESH  = 1,
   parameter  int FWFT       = 0,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_ok, rd_ok;

   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A flush cycle swallows both requests, so neither side is accepted.
   assign wr_ok = w_en & ~full  & ~clr;
   assign rd_ok = r_en & ~empty & ~clr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q  | (w_en & full  & ~clr);
      underflow_d = underflow_q | (r_en & empty & ~clr);
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_ok) wptr_d = ptr_inc(wptr_q);
         if (rd_ok) rptr_d = ptr_inc(rptr_q);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: the storage array has no reset; count/empty guarantee stale words are never presented.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr_q] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[rptr_q];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (!rst_n)     dout_q <= '0;
            else if (rd_ok) dout_q <= mem[rptr_q];
         end
         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a DEPTH=5 standard instance and a DEPTH=7 FWFT instance (AF=5, AE=2),
// both tracked every cycle by a queue-based reference model with a read-data scoreboard.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr     [2];
   logic       w_en    [2];
   logic       r_en    [2];
   logic [7:0] data_in [2];
   logic [7:0] data_out[2];
   logic       full    [2];
   logic       empty   [2];
   logic       afull   [2];
   logic       aempty  [2];
   logic [2:0] count   [2];
   logic       ovf     [2];
   logic       udf     [2];

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] mdl [2][$];
   logic [7:0] sb[$];
   bit         m_ovf[2];
   bit         m_udf[2];

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .w_en(w_en[0]), .data_in(data_in[0]),
      .r_en(r_en[0]), .data_out(data_out[0]), .full(full[0]), .empty(empty[0]),
      .almost_full(afull[0]), .almost_empty(aempty[0]), .count(count[0]),
      .overflow(ovf[0]), .underflow(udf[0]));

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(7), .AF_THRESH(5), .AE_THRESH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .w_en(w_en[1]), .data_in(data_in[1]),
      .r_en(r_en[1]), .data_out(data_out[1]), .full(full[1]), .empty(empty[1]),
      .almost_full(afull[1]), .almost_empty(aempty[1]), .count(count[1]),
      .overflow(ovf[1]), .underflow(udf[1]));

   function automatic int dep(input int i); return (i == 0) ? 5 : 7; endfunction
   function automatic int af (input int i); return (i == 0) ? 3 : 5; endfunction
   function automatic int ae (input int i); return (i == 0) ? 1 : 2; endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
   endtask

   // Reference model: the FIFO as a plain queue, updated from the inputs sampled at each edge.
   always @(posedge clk) begin
      logic [7:0] v;
      bit         f, e;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            mdl[i].delete();
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
            if (i == 0) sb.delete();
         end else if (clr[i]) begin
            mdl[i].delete();
         end else begin
            f = (mdl[i].size() == dep(i));
            e = (mdl[i].size() == 0);
            if (w_en[i] && f) m_ovf[i] = 1'b1;
            if (r_en[i] && e) m_udf[i] = 1'b1;
            if (r_en[i] && !e) begin
               v = mdl[i].pop_front();
               if (i == 0) sb.push_back(v);
            end
            if (w_en[i] && !f) mdl[i].push_back(data_in[i]);
         end
      end
   end

   // Monitor: flags and count every cycle; standard read data from the scoreboard, FWFT from the head.
   always @(negedge clk) begin
      int sz;
      for (int i = 0; i < 2; i++) begin
         sz = mdl[i].size();
         check($sformatf("count%0d", i),  32'(count[i]),  32'(sz));
         check($sformatf("full%0d", i),   32'(full[i]),   32'(sz == dep(i)));
         check($sformatf("empty%0d", i),  32'(empty[i]),  32'(sz == 0));
         check($sformatf("afull%0d", i),  32'(afull[i]),  32'(sz >= af(i)));
         check($sformatf("aempty%0d", i), 32'(aempty[i]), 32'(sz <= ae(i)));
         check($sformatf("ovf%0d", i),    32'(ovf[i]),    32'(m_ovf[i]));
         check($sformatf("udf%0d", i),    32'(udf[i]),    32'(m_udf[i]));
      end
      if (sb.size() > 0) check("sb_data0", 32'(data_out[0]), 32'(sb.pop_front()));
      check("fwft_head", 32'(data_out[1]), (mdl[1].size() > 0) ? 32'(mdl[1][0]) : 32'h0);
   end

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         clr[i] = 1'b0; w_en[i] = 1'b0; r_en[i] = 1'b0; data_in[i] = 8'h00;
      end
   endtask

   // One cycle on instance i; returns just after the edge so results can be checked.
   task automatic drive(input int i, input bit we, input bit re, input bit cl, input logic [7:0] d);
      @(negedge clk);
      idle();
      w_en[i] = we; r_en[i] = re; clr[i] = cl; data_in[i] = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_count", 32'(count[i]), 0);
         check("rst_empty", 32'(empty[i]), 1);
         check("rst_full",  32'(full[i]),  0);
         check("rst_ae",    32'(aempty[i]), 1);
         check("rst_af",    32'(afull[i]), 0);
         check("rst_ovf",   32'(ovf[i]),   0);
         check("rst_udf",   32'(udf[i]),   0);
         check("rst_dout",  32'(data_out[i]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 0x11..0x55, then one write too many.
      for (int k = 1; k <= 5; k++) begin
         drive(0, 1'b1, 1'b0, 1'b0, 8'(k * 17));
         check("fill_count", 32'(count[0]), 32'(k));
         check("fill_af",    32'(afull[0]), 32'(k >= 3));
         check("fill_full",  32'(full[0]),  32'(k == 5));
      end
      drive(0, 1'b1, 1'b0, 1'b0, 8'h66);
      check("ovf_set",    32'(ovf[0]),   1);
      check("ovf_count",  32'(count[0]), 5);

      // Drain, then wrap the pointers with a second batch.
      for (int k = 0; k < 5; k++) begin
         drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
         check("drain_data", 32'(data_out[0]), 32'((k + 1) * 17));
      end
      for (int k = 0; k < 4; k++) drive(0, 1'b1, 1'b0, 1'b0, 8'(8'hA0 + k));
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
         check("wrap_data", 32'(data_out[0]), 32'(8'hA0 + k));
      end
      check("drain_empty", 32'(empty[0]), 1);
      drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("udf_set", 32'(udf[0]), 1);

      // Simultaneous read/write at count 2, then at full, then at empty.
      do_reset();
      drive(0, 1'b1, 1'b0, 1'b0, 8'hB0);
      drive(0, 1'b1, 1'b0, 1'b0, 8'hB1);
      for (int k = 0; k < 10; k++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 8'(8'hC0 + k));
         check("rw_count", 32'(count[0]), 2);
         check("rw_data",  32'(data_out[0]), (k < 2) ? 32'(8'hB0 + k) : 32'(8'hC0 + k - 2));
      end
      for (int k = 0; k < 3; k++) drive(0, 1'b1, 1'b0, 1'b0, 8'(8'hD0 + k));
      check("rw_full", 32'(full[0]), 1);
      drive(0, 1'b1, 1'b1, 1'b0, 8'hEE);
      check("full_rw_count", 32'(count[0]), 4);
      check("full_rw_ovf",   32'(ovf[0]),   1);
      check("full_rw_data",  32'(data_out[0]), 32'h0C8);
      do_reset();
      drive(0, 1'b1, 1'b1, 1'b0, 8'h5A);
      check("empty_rw_count", 32'(count[0]), 1);
      check("empty_rw_udf",   32'(udf[0]),   1);
      check("empty_rw_ovf",   32'(ovf[0]),   0);

      // Flush at count 3 with overflow set, write in the same cycle is dropped.
      do_reset();
      for (int k = 1; k <= 6; k++) drive(0, 1'b1, 1'b0, 1'b0, 8'(k * 17));
      drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
      drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("pre_clr_count", 32'(count[0]), 3);
      drive(0, 1'b1, 1'b0, 1'b1, 8'h77);
      check("clr_count", 32'(count[0]), 0);
      check("clr_empty", 32'(empty[0]), 1);
      check("clr_ovf",   32'(ovf[0]),   1);
      check("clr_dout",  32'(data_out[0]), 32'h22);
      drive(0, 1'b1, 1'b0, 1'b0, 8'h99);
      drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("post_clr_data", 32'(data_out[0]), 32'h99);
      do_reset();
      check("rst_clears_ovf",  32'(ovf[0]), 0);
      check("rst_clears_dout", 32'(data_out[0]), 0);

      // First-word-fall-through visibility and pop.
      drive(1, 1'b1, 1'b0, 1'b0, 8'h3C);
      check("fwft_show",  32'(data_out[1]), 32'h3C);
      check("fwft_nempty", 32'(empty[1]), 0);
      drive(1, 1'b0, 1'b1, 1'b0, 8'h00);
      check("fwft_pop_empty", 32'(empty[1]), 1);
      check("fwft_pop_dout",  32'(data_out[1]), 0);

      // Random traffic on both instances with biased phases, rare flushes and one mid-stream reset.
      for (int c = 0; c < 2000; c++) begin
         int wb, rb;
         @(negedge clk);
         rst_n = (c != 1000);
         wb = ((c / 250) % 2 == 0) ? 70 : 35;
         rb = ((c / 250) % 2 == 0) ? 35 : 70;
         for (int i = 0; i < 2; i++) begin
            clr[i]     = ($urandom_range(63) == 0);
            w_en[i]    = ($urandom_range(99) < wb) && !clr[i];
            r_en[i]    = ($urandom_range(99) < rb) && !clr[i];
            data_in[i] = 8'($urandom_range(255));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
